// File: rtl/vector_ls_sequencer_if.sv
// Vector load/store sequencer bus bundle.
// Groups the command handshake, the scalar memory port and the slice buffer controls.
//   master : the sequencer (drives cmd_ready/done, memory requests and slice controls)
//   slave  : the surrounding issue stage, memory and slice buffers
// Parameters: ADDR_WIDTH word address width, NUM_SLICES slice count, SW word-select width.
interface vector_ls_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_SLICES = 4,
    parameter int unsigned SW         = 2
);
    // command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_store;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  done;
    // scalar memory port
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    // slice buffer controls
    logic [NUM_SLICES-1:0] load_en;
    logic [SW-1:0]         sel_word;
    logic                  store_en;
    logic [NUM_SLICES-1:0] serial_output;
    logic [SW-1:0]         sel_store_word;

    modport master (
        input  cmd_valid, cmd_store, cmd_addr, mem_req_ready, mem_rvalid,
        output cmd_ready, done, mem_req_valid, mem_we, mem_addr,
               load_en, sel_word, store_en, serial_output, sel_store_word
    );

    modport slave (
        output cmd_valid, cmd_store, cmd_addr, mem_req_ready, mem_rvalid,
        input  cmd_ready, done, mem_req_valid, mem_we, mem_addr,
               load_en, sel_word, store_en, serial_output, sel_store_word
    );
endinterface

// File: rtl/vector_ls_sequencer.sv
// Vector load/store sequencer.
// Splits a vector load/store of NUM_SLICES*NUM_SCALARS words into single-word memory
// transactions. Loads steer in-order read responses into the slice buffers; stores
// snapshot the vector once and then drain it word-by-word through the serial chain.
// Ports:
//   clk    clock
//   reset  asynchronous reset, active-low
//   bus    vector_ls_sequencer_if.master (command, memory port, slice controls)
module vector_ls_sequencer #(
    parameter int unsigned NUM_SLICES      = 4,
    parameter int unsigned NUM_ELEMS       = 8,
    parameter int unsigned ELEM_SIZE       = 16,
    parameter int unsigned SCALAR_SIZE     = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vector_ls_sequencer_if.master bus
);
    localparam int unsigned NUM_SCALARS = NUM_ELEMS * ELEM_SIZE / SCALAR_SIZE;
    localparam int unsigned NUM_WORDS   = NUM_SLICES * NUM_SCALARS;
    localparam int unsigned SEL_W       = (NUM_SCALARS > 1) ? $clog2(NUM_SCALARS) : 1;
    localparam int unsigned SLICE_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int unsigned CNT_W       = $clog2(NUM_WORDS + 1);
    localparam int unsigned OUT_W       = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE_CAP,
        S_STORE_WR,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      resp_cnt;
    logic [OUT_W-1:0]      outstanding;

    logic                  req_valid_c;
    logic                  accept_c;
    logic                  load_acc_c;
    logic                  rsp_c;
    logic [SLICE_W-1:0]    issue_slice_c;
    logic [SEL_W-1:0]      issue_word_c;
    logic [SLICE_W-1:0]    resp_slice_c;
    logic [SEL_W-1:0]      resp_word_c;

    // word index k -> (slice, word-within-slice)
    assign issue_slice_c = SLICE_W'(32'(issue_cnt) / NUM_SCALARS);
    assign issue_word_c  = SEL_W'(32'(issue_cnt) % NUM_SCALARS);
    assign resp_slice_c  = SLICE_W'(32'(resp_cnt) / NUM_SCALARS);
    assign resp_word_c   = SEL_W'(32'(resp_cnt) % NUM_SCALARS);

    // Responses only count while a load still expects data; anything else is stray.
    assign rsp_c      = (state == S_LOAD) && bus.mem_rvalid && (resp_cnt < CNT_W'(NUM_WORDS));
    assign accept_c   = req_valid_c && bus.mem_req_ready;
    assign load_acc_c = accept_c && (state == S_LOAD);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and request-valid decode
    always_comb begin
        state_nxt   = state;
        req_valid_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = bus.cmd_store ? S_STORE_CAP : S_LOAD;
                end
            end
            S_LOAD: begin
                req_valid_c = (issue_cnt < CNT_W'(NUM_WORDS)) &&
                              (outstanding < OUT_W'(MAX_OUTSTANDING));
                if (rsp_c && (resp_cnt == CNT_W'(NUM_WORDS - 1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_STORE_CAP: begin
                state_nxt = S_STORE_WR;
            end
            S_STORE_WR: begin
                req_valid_c = 1'b1;
                if (bus.mem_req_ready && (issue_cnt == CNT_W'(NUM_WORDS - 1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, issue/response counters and read window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_addr   <= '0;
            issue_cnt   <= '0;
            resp_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if ((state == S_IDLE) && bus.cmd_valid) begin
                base_addr <= bus.cmd_addr;
            end
            if (state == S_DONE) begin
                issue_cnt   <= '0;
                resp_cnt    <= '0;
                outstanding <= '0;
            end else begin
                if (accept_c) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                end
                if (rsp_c) begin
                    resp_cnt <= resp_cnt + CNT_W'(1);
                end
                // accept and response in the same cycle cancel out
                case ({load_acc_c, rsp_c})
                    2'b10:   outstanding <= outstanding + OUT_W'(1);
                    2'b01:   outstanding <= outstanding - OUT_W'(1);
                    default: outstanding <= outstanding;
                endcase
            end
        end
    end

    // Outputs decoded from registered state; load_en follows mem_rvalid directly.
    assign bus.cmd_ready      = (state == S_IDLE);
    assign bus.done           = (state == S_DONE);
    assign bus.mem_req_valid  = req_valid_c;
    assign bus.mem_we         = req_valid_c && (state == S_STORE_WR);
    assign bus.mem_addr       = req_valid_c ? (base_addr + ADDR_WIDTH'(issue_cnt)) : '0;
    assign bus.load_en        = rsp_c ? (NUM_SLICES'(1) << resp_slice_c) : '0;
    assign bus.sel_word       = (state == S_LOAD) ? resp_word_c : '0;
    assign bus.store_en       = (state == S_STORE_CAP);
    assign bus.serial_output  = (state == S_STORE_WR) ? (NUM_SLICES'(1) << issue_slice_c) : '0;
    assign bus.sel_store_word = (state == S_STORE_WR) ? issue_word_c : '0;
endmodule

// File: tb/tb_vector_ls_sequencer.sv
// Testbench for vector_ls_sequencer.
// Drives directed and randomized load/store commands and compares every output, every
// cycle, against a transaction-level model: the list of word addresses a command must
// produce, a queue of in-flight reads with their due times, and the word each response fills.
module tb_vector_ls_sequencer;
    localparam int N    = 16;
    localparam int NSC  = 4;
    localparam int MAXO = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    vector_ls_sequencer_if #(.ADDR_WIDTH(32), .NUM_SLICES(4), .SW(2)) bus ();

    vector_ls_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // outputs that must be at their reset values
    task automatic chk_idle(input string tag);
        chk({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        chk({tag, " done"}, 64'(bus.done), 64'(0));
        chk({tag, " mem_req_valid"}, 64'(bus.mem_req_valid), 64'(0));
        chk({tag, " load_en"}, 64'(bus.load_en), 64'(0));
        chk({tag, " store_en"}, 64'(bus.store_en), 64'(0));
        chk({tag, " serial_output"}, 64'(bus.serial_output), 64'(0));
    endtask

    // Runs one command to completion (or to a reset abort after abort_at accepts).
    // rmode: 0 ready always, 1 ready toggles 1/0, 2 random ready.
    // lat: read latency after accept; holdoff: no rvalid before this cycle of the command.
    task automatic run_cmd(input bit st, input logic [31:0] base, input int rmode,
                           input int lat, input int holdoff, input bit hold,
                           input int abort_at);
        int   ph;        // 0 idle, 1 load, 2 capture, 3 write, 4 done
        int   issued;
        int   resp;
        int   due_q[$];
        bit   rdy;
        bit   rv;
        bit   ev;
        bit   finished;
        logic [3:0] le;
        ph = 0; issued = 0; resp = 0; finished = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_store = st;
        bus.cmd_addr  = base;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (abort_at >= 0 && issued == abort_at && ph == 1) begin
                // abort mid-load, then replay three late responses
                bus.mem_rvalid = 1'b0;
                bus.mem_req_ready = 1'b1;
                reset = 1'b0;
                #1;
                chk_idle("abort");
                @(posedge clk); #1;
                reset = 1'b1;
                bus.cmd_valid = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    bus.mem_rvalid = 1'b1;
                    @(negedge clk);
                    chk_idle("late_rvalid");
                    @(posedge clk); #1;
                end
                bus.mem_rvalid = 1'b0;
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rv = (due_q.size() > 0) && (due_q[0] <= cyc) && (cyc >= holdoff);
            bus.mem_req_ready = rdy;
            bus.mem_rvalid    = rv;
            ev = (ph == 1) ? (issued < N && due_q.size() < MAXO) : (ph == 3);
            le = (ph == 1 && rv) ? (4'b0001 << (resp / NSC)) : 4'b0000;

            @(negedge clk);
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(ph == 0));
            chk("done", 64'(bus.done), 64'(ph == 4));
            chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(ev));
            if (ev) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(32'(base + 32'(issued))));
                chk("mem_we", 64'(bus.mem_we), 64'(ph == 3));
            end
            chk("load_en", 64'(bus.load_en), 64'(le));
            if (le != 4'b0000) chk("sel_word", 64'(bus.sel_word), 64'(resp % NSC));
            chk("store_en", 64'(bus.store_en), 64'(ph == 2));
            chk("serial_output", 64'(bus.serial_output),
                64'((ph == 3) ? (4'b0001 << (issued / NSC)) : 4'b0000));
            if (ph == 3) chk("sel_store_word", 64'(bus.sel_store_word), 64'(issued % NSC));

            if (ph == 0) begin
                ph = st ? 2 : 1;
            end else if (ph == 1) begin
                if (ev && rdy) begin
                    due_q.push_back(cyc + lat);
                    issued++;
                end
                if (rv) begin
                    void'(due_q.pop_front());
                    resp++;
                end
                if (resp == N) ph = 4;
            end else if (ph == 2) begin
                ph = 3;
            end else if (ph == 3) begin
                if (rdy) begin
                    issued++;
                    if (issued == N) ph = 4;
                end
            end else begin
                finished = 1'b1;
            end

            @(posedge clk); #1;
            if (!hold && ph != 0) bus.cmd_valid = 1'b0;
        end
        bus.mem_rvalid    = 1'b0;
        bus.mem_req_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_store     = 1'b0;
        bus.cmd_addr      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset mem_we", 64'(bus.mem_we), 64'(0));
        chk("reset mem_addr", 64'(bus.mem_addr), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        // stray memory activity while idle is ignored
        bus.mem_rvalid = 1'b1;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk_idle("idle_stray");
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_req_ready = 1'b0;

        // load, 2-cycle latency, ready always
        run_cmd(1'b0, 32'h0000_0100, 0, 2, 0, 1'b0, -1);
        // load with responses held off for 10 cycles: window fills to 4 then stalls
        run_cmd(1'b0, 32'h0000_0200, 0, 1, 10, 1'b0, -1);
        // store with ready toggling
        run_cmd(1'b1, 32'h0000_0020, 1, 1, 0, 1'b0, -1);
        // address wrap
        run_cmd(1'b0, 32'hFFFF_FFFE, 0, 1, 0, 1'b0, -1);
        // reset abort after 5 accepts, then a normal command
        run_cmd(1'b0, 32'h0000_0400, 0, 3, 0, 1'b0, 5);
        run_cmd(1'b0, 32'h0000_0500, 0, 1, 0, 1'b0, -1);
        // cmd_valid held across two commands
        run_cmd(1'b0, 32'h0000_0600, 0, 1, 0, 1'b1, -1);
        run_cmd(1'b1, 32'h0000_0700, 0, 1, 0, 1'b1, -1);
        bus.cmd_valid = 1'b0;
        // randomized commands
        for (int i = 0; i < 8; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 32'($urandom), 2,
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 6)), 1'b0, -1);
        end
        @(negedge clk);
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
